// File: rtl/calibration_sequencer.sv
// Speaker calibration sequencer: per channel, waits a settle period, fires an
// impulse/record trigger, and waits for the recording with timeout and retries.
module calibration_sequencer #(
    parameter int NUM_CHANNELS    = 4,
    parameter int SETTLE_SAMPLES  = 4800,
    parameter int TIMEOUT_SAMPLES = 96000,
    parameter int MAX_RETRIES     = 2
) (
    input  logic                    audio_clk,
    input  logic                    rst_in,
    input  logic                    audio_trigger,
    input  logic                    start_in,
    input  logic                    abort_in,
    input  logic                    impulse_recorded_in,
    output logic                    record_trigger_out,
    output logic [3:0]              channel_sel_out,
    output logic                    busy_out,
    output logic                    done_out,
    output logic                    error_out,
    output logic [NUM_CHANNELS-1:0] failed_mask_out
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        TRIGGER,
        WAIT_REC,
        NEXT,
        DONE
    } state_t;

    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_SAMPLES - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_SAMPLES - 1);
    localparam logic [3:0]  CHAN_LAST    = 4'(NUM_CHANNELS - 1);
    localparam logic [2:0]  RETRY_LIMIT  = 3'(MAX_RETRIES);

    state_t      state;
    logic [15:0] settle_cnt;
    logic [19:0] timeout_cnt;
    logic [2:0]  retry_cnt;

    always_ff @(posedge audio_clk or posedge rst_in) begin
        if (rst_in) begin
            state              <= IDLE;
            settle_cnt         <= '0;
            timeout_cnt        <= '0;
            retry_cnt          <= '0;
            record_trigger_out <= 1'b0;
            channel_sel_out    <= '0;
            busy_out           <= 1'b0;
            done_out           <= 1'b0;
            error_out          <= 1'b0;
            failed_mask_out    <= '0;
        end else begin
            record_trigger_out <= 1'b0;
            done_out           <= 1'b0;
            // Pulses are raised on the transition into their state so they stay registered.
            if (state != IDLE && abort_in) begin
                state    <= IDLE;
                busy_out <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_in) begin
                            failed_mask_out <= '0;
                            error_out       <= 1'b0;
                            channel_sel_out <= '0;
                            retry_cnt       <= '0;
                            settle_cnt      <= '0;
                            busy_out        <= 1'b1;
                            state           <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (audio_trigger) begin
                            if (settle_cnt == SETTLE_LAST) begin
                                record_trigger_out <= 1'b1;
                                state              <= TRIGGER;
                            end else begin
                                settle_cnt <= settle_cnt + 16'd1;
                            end
                        end
                    end
                    TRIGGER: begin
                        timeout_cnt <= '0;
                        state       <= WAIT_REC;
                    end
                    WAIT_REC: begin
                        if (impulse_recorded_in) begin
                            state <= NEXT;
                        end else if (audio_trigger) begin
                            if (timeout_cnt == TIMEOUT_LAST) begin
                                if (retry_cnt != RETRY_LIMIT) begin
                                    retry_cnt  <= retry_cnt + 3'd1;
                                    settle_cnt <= '0;
                                    state      <= SETTLE;
                                end else begin
                                    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                                        if (channel_sel_out == 4'(i))
                                            failed_mask_out[i] <= 1'b1;
                                    end
                                    error_out <= 1'b1;
                                    state     <= NEXT;
                                end
                            end else begin
                                timeout_cnt <= timeout_cnt + 20'd1;
                            end
                        end
                    end
                    NEXT: begin
                        if (channel_sel_out == CHAN_LAST) begin
                            done_out <= 1'b1;
                            state    <= DONE;
                        end else begin
                            channel_sel_out <= channel_sel_out + 4'd1;
                            retry_cnt       <= '0;
                            settle_cnt      <= '0;
                            state           <= SETTLE;
                        end
                    end
                    DONE: begin
                        busy_out <= 1'b0;
                        state    <= IDLE;
                    end
                    default: begin
                        busy_out <= 1'b0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calibration_sequencer.sv
// Scoreboard bench for calibration_sequencer: a run-level model predicts trigger/done
// events (channel, strobes since previous event, mask, error); a monitor checks them.
module tb_calibration_sequencer;

    localparam int NCH    = 2;
    localparam int SETTLE = 3;
    localparam int TMO    = 5;
    localparam int MAXR   = 1;
    localparam int PERIOD = 4;

    logic       audio_clk = 1'b0;
    logic       rst_in = 1'b1;
    logic       audio_trigger = 1'b0;
    logic       start_in = 1'b0;
    logic       abort_in = 1'b0;
    logic       impulse_recorded_in = 1'b0;
    logic       record_trigger_out;
    logic [3:0] channel_sel_out;
    logic       busy_out;
    logic       done_out;
    logic       error_out;
    logic [1:0] failed_mask_out;

    calibration_sequencer #(
        .NUM_CHANNELS(NCH),
        .SETTLE_SAMPLES(SETTLE),
        .TIMEOUT_SAMPLES(TMO),
        .MAX_RETRIES(MAXR)
    ) dut (
        .audio_clk(audio_clk),
        .rst_in(rst_in),
        .audio_trigger(audio_trigger),
        .start_in(start_in),
        .abort_in(abort_in),
        .impulse_recorded_in(impulse_recorded_in),
        .record_trigger_out(record_trigger_out),
        .channel_sel_out(channel_sel_out),
        .busy_out(busy_out),
        .done_out(done_out),
        .error_out(error_out),
        .failed_mask_out(failed_mask_out)
    );

    always #5 audio_clk = ~audio_clk;

    typedef struct {
        bit is_done;
        int ch;
        int strobes;
        int mask;
        int err;
    } ev_t;

    ev_t exp_q[$];
    int  resp_q[$];   // per trigger: strobe index at which the recorder answers, 0 = never
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  start_gen = 0;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Strobe generator and recorder model
    initial begin
        int pend_k;
        int pend_cnt;
        pend_k = 0;
        pend_cnt = 0;
        forever begin
            @(posedge audio_clk);
            #1;
            cyc++;
            if (record_trigger_out) begin
                pend_k = (resp_q.size() != 0) ? resp_q.pop_front() : 0;
                pend_cnt = 0;
            end
            audio_trigger = (cyc % PERIOD == 0);
            impulse_recorded_in = 1'b0;
            if (audio_trigger && pend_k != 0) begin
                pend_cnt++;
                if (pend_cnt == pend_k) begin
                    impulse_recorded_in = 1'b1;
                    pend_k = 0;
                end
            end
        end
    end

    // Monitor: counts strobes between events and checks each event against the queue
    initial begin
        int   scnt;
        int   seen_gen;
        ev_t  e;
        scnt = 0;
        seen_gen = 0;
        forever begin
            @(negedge audio_clk);
            if (start_gen != seen_gen) begin
                seen_gen = start_gen;
                scnt = 0;
            end
            if (audio_trigger) scnt++;
            if (record_trigger_out || done_out) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got trig=%0d done=%0d expected none (t=%0t)",
                             record_trigger_out, done_out, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_is_done", int'(done_out), int'(e.is_done));
                    chk("event_strobes", scnt, e.strobes);
                    chk("event_channel", int'(channel_sel_out), e.ch);
                    if (e.is_done) begin
                        chk("done_mask", int'(failed_mask_out), e.mask);
                        chk("done_error", int'(error_out), e.err);
                    end
                end
                scnt = 0;
            end
        end
    end

    task automatic push_trig(input int ch, input int strobes, input int k);
        ev_t e;
        e.is_done = 1'b0;
        e.ch = ch;
        e.strobes = strobes;
        e.mask = 0;
        e.err = 0;
        exp_q.push_back(e);
        resp_q.push_back(k);
    endtask

    // Run model: k[ch][attempt] is the recorder answer strobe (0 = no answer)
    task automatic build(input int k0a, input int k0b, input int k1a, input int k1b);
        int   k[NCH][MAXR+1];
        int   carry;
        int   mask;
        ev_t  e;
        k[0][0] = k0a; k[0][1] = k0b; k[1][0] = k1a; k[1][1] = k1b;
        carry = 0;
        mask = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            for (int a = 0; a <= MAXR; a++) begin
                push_trig(ch, carry + SETTLE, k[ch][a]);
                if (k[ch][a] != 0) begin
                    carry = k[ch][a];
                    break;
                end
                carry = TMO;
                if (a == MAXR) mask = mask | (1 << ch);
            end
        end
        e.is_done = 1'b1;
        e.ch = NCH - 1;
        e.strobes = carry;
        e.mask = mask;
        e.err = (mask != 0) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        do begin
            @(posedge audio_clk);
            #2;
        end while (cyc % PERIOD != 2);
        start_in = 1'b1;
        start_gen++;
        @(posedge audio_clk);
        #2;
        start_in = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done_out && n < 3000) begin
            @(negedge audio_clk);
            n++;
        end
        chk({name, "_done_seen"}, int'(done_out), 1);
        @(negedge audio_clk);
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic wait_events_drained();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge audio_clk);
            n++;
        end
        chk("events_drained", exp_q.size(), 0);
    endtask

    function automatic int rand_k();
        return ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, TMO));
    endfunction

    initial begin
        #3;
        chk("reset_busy", int'(busy_out), 0);
        chk("reset_trig", int'(record_trigger_out), 0);
        chk("reset_chan", int'(channel_sel_out), 0);
        chk("reset_mask", int'(failed_mask_out), 0);
        chk("reset_error", int'(error_out), 0);
        chk("reset_done", int'(done_out), 0);
        repeat (3) @(posedge audio_clk);
        #2;
        rst_in = 1'b0;
        repeat (20) @(negedge audio_clk);
        chk("idle_without_start", int'(busy_out), 0);

        // all channels answer after 2 strobes
        build(2, 0, 2, 0);
        pulse_start();
        wait_done("basic");

        // ch0 never answers, ch1 answers
        build(0, 0, 2, 0);
        pulse_start();
        wait_done("ch0_fail");

        // answer coincident with the final timeout strobe
        build(TMO, 0, 1, 0);
        pulse_start();
        wait_done("coincident");

        // abort during WAIT_REC of ch1 after ch0 failed
        push_trig(0, SETTLE, 0);
        push_trig(0, TMO + SETTLE, 0);
        push_trig(1, TMO + SETTLE, 0);
        pulse_start();
        wait_events_drained();
        repeat (8) @(posedge audio_clk);
        #2;
        abort_in = 1'b1;
        @(posedge audio_clk);
        #2;
        abort_in = 1'b0;
        @(negedge audio_clk);
        chk("abort_busy", int'(busy_out), 0);
        chk("abort_mask_kept", int'(failed_mask_out), 1);
        chk("abort_error_kept", int'(error_out), 1);
        repeat (40) @(negedge audio_clk);
        chk("abort_stays_idle", int'(busy_out), 0);
        build(2, 0, 3, 0);
        pulse_start();
        @(negedge audio_clk);
        chk("restart_mask", int'(failed_mask_out), 0);
        chk("restart_error", int'(error_out), 0);
        chk("restart_chan", int'(channel_sel_out), 0);
        chk("restart_busy", int'(busy_out), 1);
        wait_done("after_abort");

        // asynchronous reset mid-SETTLE of ch1 with mask already set
        push_trig(0, SETTLE, 0);
        push_trig(0, TMO + SETTLE, 0);
        pulse_start();
        wait_events_drained();
        repeat (22) @(negedge audio_clk);
        chk("midrun_mask", int'(failed_mask_out), 1);
        chk("midrun_chan", int'(channel_sel_out), 1);
        @(posedge audio_clk);
        #2;
        rst_in = 1'b1;
        #1;
        chk("async_rst_busy", int'(busy_out), 0);
        chk("async_rst_mask", int'(failed_mask_out), 0);
        chk("async_rst_error", int'(error_out), 0);
        chk("async_rst_chan", int'(channel_sel_out), 0);
        repeat (3) @(posedge audio_clk);
        #2;
        rst_in = 1'b0;
        repeat (60) @(negedge audio_clk);
        chk("post_rst_idle", int'(busy_out), 0);

        // start held high across two runs
        build(rand_k(), rand_k(), rand_k(), rand_k());
        build(rand_k(), rand_k(), rand_k(), rand_k());
        do begin
            @(posedge audio_clk);
            #2;
        end while (cyc % PERIOD != 2);
        start_in = 1'b1;
        start_gen++;
        begin
            int n;
            n = 0;
            while (!done_out && n < 3000) begin
                @(negedge audio_clk);
                n++;
            end
            chk("held_first_done", int'(done_out), 1);
        end
        @(negedge audio_clk);
        chk("held_idle_gap", int'(busy_out), 0);
        @(negedge audio_clk);
        chk("held_restart", int'(busy_out), 1);
        @(posedge audio_clk);
        #2;
        start_in = 1'b0;
        wait_done("held_second");
        repeat (40) @(negedge audio_clk);
        chk("held_no_third", int'(busy_out), 0);

        // randomized runs
        for (int r = 0; r < 12; r++) begin
            build(rand_k(), rand_k(), rand_k(), rand_k());
            pulse_start();
            wait_done("random");
            repeat ($urandom_range(1, 10)) @(posedge audio_clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
